// File: rtl/lp_filter_sampler.sv
// Decimating sampler for the low-pass filter output. Masks the start-up transient
// with a settle counter, then captures one sample every DECIM+1 CE cycles into a
// single valid/ready holding register along with its delta from the previous capture.
module lp_filter_sampler #(
  parameter int unsigned DATA_BITS     = 28,
  parameter int unsigned DECIM_BITS    = 8,
  parameter int unsigned SETTLE_CYCLES = 64
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        CE,
  input  logic [DATA_BITS-1:0]        IN_VALUE,
  input  logic [DECIM_BITS-1:0]       DECIM,
  output logic [DATA_BITS-1:0]        OUT_VALUE,
  output logic signed [DATA_BITS:0]   OUT_DELTA,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic                        SETTLED,
  output logic                        OVERRUN,
  input  logic                        CLEAR_OVERRUN
);

  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);

  typedef enum logic [0:0] {StSettle, StRun} state_e;

  state_e                 state;
  logic [SettleW-1:0]     settle_cnt;
  logic [DECIM_BITS-1:0]  decim_cnt;
  logic [DATA_BITS-1:0]   prev;
  logic                   first;
  logic                   tick;
  logic [DATA_BITS:0]     delta_raw;

  // Sample strobe; >= lets a lowered DECIM force an immediate tick.
  always_comb begin
    tick      = (state == StRun) && CE && (decim_cnt >= DECIM);
    // Zero-extended operands, so the DATA_BITS+1 result can never overflow.
    delta_raw = {1'b0, IN_VALUE} - {1'b0, prev};
  end

  // Settle/run sequencing, decimation counter and registered output stage.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= StSettle;
      settle_cnt <= '0;
      decim_cnt  <= '0;
      prev       <= '0;
      first      <= 1'b1;
      OUT_VALUE  <= '0;
      OUT_DELTA  <= '0;
      OUT_VALID  <= 1'b0;
      SETTLED    <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      case (state)
        StSettle: begin
          if (CE) begin
            if (settle_cnt == SettleLast) begin
              state   <= StRun;
              SETTLED <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
        end
        StRun: begin
          if (CE) begin
            decim_cnt <= tick ? '0 : decim_cnt + 1'b1;
          end
        end
        default: state <= StSettle;
      endcase

      // A tick reloads the holding register even if the old sample is being consumed.
      if (tick) begin
        OUT_VALUE <= IN_VALUE;
        OUT_DELTA <= first ? '0 : $signed(delta_raw);
        prev      <= IN_VALUE;
        first     <= 1'b0;
        OUT_VALID <= 1'b1;
      end else if (OUT_VALID && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end

      // Overwriting an unconsumed sample is sticky; a new overrun beats the clear.
      if (tick && OUT_VALID && !OUT_READY) begin
        OVERRUN <= 1'b1;
      end else if (CLEAR_OVERRUN) begin
        OVERRUN <= 1'b0;
      end
    end
  end

endmodule

// File: doc/lp_filter_sampler.md
# lp_filter_sampler

Consumer-side companion to the low-pass filter stage. It reads the filter's smoothed output, decimates it at a runtime-programmable rate, and presents each sample with its delta from the previous sample. Output uses a valid/ready handshake with a single holding register, so slow downstream logic (register bank, serializer) never stalls the filter pipeline. It also masks the filter's start-up transient after reset via a settle counter.

## Interface
- DATA_BITS, 28, width of filtered input and output sample
- DECIM_BITS, 8, width of decimation control
- SETTLE_CYCLES, 64, CE cycles discarded after reset before sampling starts (must be >= 1)

- CLK  in  1  clock
- RESET  in  1  reset, synchronous, active-high
- CE  in  1  filter pipeline enable; all counting and sampling advance only on cycles with CE=1
- IN_VALUE  in  DATA_BITS  filtered value from filter stage (unsigned)
- DECIM  in  DECIM_BITS  sample once every DECIM+1 CE cycles
- OUT_VALUE  out  DATA_BITS  captured sample
- OUT_DELTA  out  DATA_BITS+1  signed, IN_VALUE at capture minus previous captured value
- OUT_VALID  out  1  sample available
- OUT_READY  in  1  downstream accepts sample when OUT_VALID & OUT_READY
- SETTLED  out  1  1 once settle phase complete
- OVERRUN  out  1  sticky: an unconsumed sample was overwritten
- CLEAR_OVERRUN  in  1  clears OVERRUN

## Operation
- States: SETTLE, RUN. RESET -> SETTLE; settle counter, decim counter, OUT_VALUE, OUT_DELTA, previous-sample register, OUT_VALID, OVERRUN, SETTLED all 0.
- SETTLE: settle counter increments on each CE cycle; on the CE cycle where it reaches SETTLE_CYCLES-1, go to RUN, SETTLED=1 from next cycle. No captures in SETTLE.
- RUN: decim counter increments on each CE cycle. Tick = CE & (counter >= DECIM); on tick counter resets to 0. Using >= means lowering DECIM below the current count forces a tick on the next CE cycle.
- On tick: OUT_VALUE <= IN_VALUE; OUT_DELTA <= IN_VALUE - prev (DATA_BITS+1 signed, zero-extended operands, no overflow possible); prev <= IN_VALUE; OUT_VALID <= 1.
- First tick after entering RUN: OUT_DELTA = 0 (first-sample flag, cleared on that tick).
- Handshake: OUT_VALID & OUT_READY consumes sample; OUT_VALID falls next cycle unless a tick occurs in the same cycle.
- Tick with OUT_VALID=1 and OUT_READY=0: newest sample overwrites holding register, OVERRUN <= 1. Tick with OUT_VALID & OUT_READY: handshake completes, new sample loaded, OUT_VALID stays 1, no overrun.
- prev always tracks the last captured value, consumed or overwritten.
- CLEAR_OVERRUN clears OVERRUN; if an overrun occurs in the same cycle, set wins.
- CE=0: counters, state frozen; handshake still completes (OUT_READY acts regardless of CE).
- RESET mid-operation: pending sample dropped, OUT_VALID=0 next cycle, returns to SETTLE; RESET overrides all other inputs.
- OUT_VALUE/OUT_DELTA stable while OUT_VALID=1 and not consumed, except on overwrite.

## Timing
- All outputs registered; capture latency 1 cycle: IN_VALUE sampled at tick edge appears on OUT_VALUE with OUT_VALID=1 the cycle after.
- With CE=1 continuously: SETTLED rises SETTLE_CYCLES cycles after RESET deasserts; first OUT_VALID at SETTLE_CYCLES+DECIM+1 cycles; thereafter one tick every DECIM+1 cycles.
- DECIM=0: tick every CE cycle; full throughput only with OUT_READY held 1.
- OUT_READY has no combinational path to any output.

## Test plan
- Reset, CE=1, SETTLE_CYCLES=64, DECIM=3, IN_VALUE ramp +1/cycle, OUT_READY=1 -> SETTLED high after 64 cycles; OUT_VALID pulses every 4 cycles; first OUT_DELTA=0, then OUT_DELTA=+4 each sample.
- DECIM=0, OUT_READY=1, IN_VALUE alternating 100/40 -> OUT_VALID continuous, OUT_DELTA alternating -60/+60, OVERRUN stays 0.
- DECIM=1, OUT_READY=0 for 6 cycles -> OUT_VALUE holds newest sample, OVERRUN=1; assert CLEAR_OVERRUN alone -> OVERRUN=0; CLEAR_OVERRUN coincident with new overrun -> OVERRUN stays 1.
- CE toggling 1/0, DECIM=2 -> tick every 3 CE=1 cycles (6 clocks); handshake with OUT_READY during CE=0 still drops OUT_VALID.
- Counter at 7 with DECIM=10, then DECIM changed to 2 -> tick on next CE cycle, counter restarts at 0, subsequent ticks every 3 CE cycles.
- RESET asserted while OUT_VALID=1 and OVERRUN=1 -> next cycle OUT_VALID=0, OVERRUN=0, SETTLED=0, OUT_VALUE=0; first post-reset sample OUT_DELTA=0.
